// File: rtl/evm_pkg.sv
// Shared definitions for the EVM ballot logic.
//   state_t     : ballot FSM states (IDLE / ARMED / ACK)
//   MODE_VOTE   : mode input value for normal voting operation
//   MODE_RESULT : mode input value for tally readout
package evm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        ACK   = 2'd2
    } state_t;

    localparam logic MODE_VOTE   = 1'b0;
    localparam logic MODE_RESULT = 1'b1;

endpackage

// File: rtl/vote_counter.sv
// Saturating per-candidate tally.
// Ports:
//   clock   in   system clock
//   reset   in   synchronous active-low reset, clears the tally
//   inc     in   add one to the tally (ignored once at maximum)
//   count   out  current tally
//   at_max  out  tally is at 2**CNT_W-1
module vote_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             at_max
);

    assign at_max = (count == {CNT_W{1'b1}});

    always_ff @(posedge clock) begin
        if (!reset) begin
            count <= '0;
        end else if (inc && !at_max) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/vote_logger.sv
// Ballot logger: turns debounced candidate pulses into stored, saturating tallies,
// one ballot per officer arm, with a timed voter acknowledge and a result readout mode.
// Ports:
//   clock        in   system clock
//   reset        in   synchronous active-low reset
//   mode         in   0 = voting, 1 = result readout
//   arm          in   officer pulse that opens one ballot
//   valid_vote   in   per-candidate vote pulses (bit i = candidate i)
//   sel          in   candidate shown on vote_count in result mode
//   ballot_open  out  ballot armed, waiting for a vote
//   ack_led      out  voter acknowledge, held ACK_CYCLES cycles
//   vote_err     out  one-cycle pulse on a rejected multi-candidate press
//   vote_count   out  tally of sel in result mode, 0 otherwise
//   total_votes  out  number of accepted (counted) votes
//
// state | meaning
// IDLE  | locked, waiting for an officer arm
// ARMED | ballot open, waiting for a single-candidate press
// ACK   | vote taken, acknowledge timer running
module vote_logger
    import evm_pkg::*;
#(
    parameter  int NUM_CAND   = 4,
    parameter  int CNT_W      = 8,
    parameter  int ACK_CYCLES = 50000,
    localparam int SEL_W      = $clog2(NUM_CAND),
    localparam int TOT_W      = CNT_W + SEL_W
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                mode,
    input  logic                arm,
    input  logic [NUM_CAND-1:0] valid_vote,
    input  logic [SEL_W-1:0]    sel,
    output logic                ballot_open,
    output logic                ack_led,
    output logic                vote_err,
    output logic [CNT_W-1:0]    vote_count,
    output logic [TOT_W-1:0]    total_votes
);

    // Wide enough to hold ACK_CYCLES-1 even when ACK_CYCLES is 1.
    localparam int               ACK_W    = $clog2(ACK_CYCLES + 1);
    localparam logic [ACK_W-1:0] ACK_LOAD = ACK_W'(ACK_CYCLES - 1);

    state_t              state;
    state_t              state_n;
    logic [ACK_W-1:0]    ack_cnt;
    logic [ACK_W-1:0]    ack_cnt_n;
    logic                vote_err_n;
    logic [CNT_W-1:0]    vote_count_n;

    logic                one_hot;
    logic                multi;
    logic                accept;
    logic                bump_total;
    logic [NUM_CAND-1:0] inc;
    logic [NUM_CAND-1:0] at_max;

    // Padded to the full sel range so out-of-range selections read 0.
    logic [CNT_W-1:0]    tally [2**SEL_W];

    assign one_hot = (valid_vote != '0) &&
                     ((valid_vote & (valid_vote - NUM_CAND'(1))) == '0);
    assign multi   = (valid_vote != '0) && !one_hot;
    assign accept  = (state == ARMED) && (mode == MODE_VOTE) && one_hot;
    assign inc     = accept ? valid_vote : '0;
    // A vote for a saturated candidate is consumed but not counted anywhere.
    assign bump_total = |(inc & ~at_max);

    for (genvar i = 0; i < NUM_CAND; i++) begin : g_cand
        vote_counter #(
            .CNT_W (CNT_W)
        ) u_vote_counter (
            .clock  (clock),
            .reset  (reset),
            .inc    (inc[i]),
            .count  (tally[i]),
            .at_max (at_max[i])
        );
    end

    for (genvar i = NUM_CAND; i < 2**SEL_W; i++) begin : g_pad
        assign tally[i] = '0;
    end

    always_comb begin
        state_n      = state;
        ack_cnt_n    = ack_cnt;
        vote_err_n   = 1'b0;
        vote_count_n = '0;

        if (mode == MODE_RESULT) begin
            state_n      = IDLE;
            ack_cnt_n    = '0;
            vote_count_n = tally[sel];
        end else begin
            case (state)
                IDLE: begin
                    if (arm) begin
                        state_n = ARMED;
                    end
                end
                ARMED: begin
                    if (one_hot) begin
                        state_n   = ACK;
                        ack_cnt_n = ACK_LOAD;
                    end else if (multi) begin
                        vote_err_n = 1'b1;
                    end
                end
                ACK: begin
                    if (ack_cnt == '0) begin
                        state_n = IDLE;
                    end else begin
                        ack_cnt_n = ack_cnt - ACK_W'(1);
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= IDLE;
            ack_cnt     <= '0;
            ballot_open <= 1'b0;
            ack_led     <= 1'b0;
            vote_err    <= 1'b0;
            vote_count  <= '0;
            total_votes <= '0;
        end else begin
            state       <= state_n;
            ack_cnt     <= ack_cnt_n;
            ballot_open <= (state_n == ARMED);
            ack_led     <= (state_n == ACK);
            vote_err    <= vote_err_n;
            vote_count  <= vote_count_n;
            if (bump_total) begin
                total_votes <= total_votes + TOT_W'(1);
            end
        end
    end

endmodule
